pic_init_sequencer: RTL
=======================

# pic_init_sequencer

Command-word sequencer for the 8259-style interrupt controller. It sits between the CPU bus interface and the interrupt handler datapath. It decodes CPU writes (CS_n/WR_n/A0/data) into the ICW1→ICW2→(ICW3)→(ICW4) initialization sequence and the OCW1/OCW2/OCW3 operation commands. Its registered outputs drive the handler: mask register, vector base, read mode, EOI command and level, and mode flags.

## Interface
- No parameters.
- `clk` in 1: single system clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `CS_n` in 1: chip select, active low.
- `WR_n` in 1: write strobe, active low; a write commits on its rising edge as sampled by `clk`.
- `A0` in 1: command-word address bit.
- `din` in 8: CPU write data.
- `OCW1` out 8: interrupt mask register (IMR); bit n = 1 masks IRQn.
- `VEC_ADD` out 5: vector base T7..T3, from ICW2 `din[7:3]`.
- `read_mode` out 1: 0 = IRR on status read, 1 = ISR.
- `EOI_command` out 3: OCW2 `din[7:5]` (R, SL, EOI).
- `int_level` out 3: OCW2 `din[2:0]`.
- `eoi_valid` out 1: one-cycle pulse on every OCW2 commit.
- `poll_req` out 1: one-cycle pulse on OCW3 commit with P = `din[2]` = 1.
- `EOI_mode` out 1: AEOI, from ICW4 `din[1]`.
- `ltim` out 1: level-trigger mode, from ICW1 `din[3]`.
- `single` out 1: from ICW1 `din[1]`.
- `special_mask` out 1: special mask mode.
- `sfnm` out 1: ICW4 `din[4]`.
- `cascade` out 8: ICW3 byte.
- `init_done` out 1: high while in READY.

## Operation
- Write capture:
  - Each clock, sample `WR_n`, `CS_n`, `A0` and `din` into a history register.
  - A commit occurs on the edge where sampled `WR_n` = 1 and the previous sample had `WR_n` = 0 and `CS_n` = 0.
  - The commit uses the `A0`/`din` from that previous (last-low) sample.
  - A write with `CS_n` high at its last low cycle is ignored.
- Decode, per commit:
  - ICW1: `A0` = 0 and `din[4]` = 1.
  - OCW2: `A0` = 0, `din[4:3]` = 00.
  - OCW3: `A0` = 0, `din[4:3]` = 01.
  - `A0` = 1: ICW2/3/4 or OCW1, depending on state.
- States: IDLE, WAIT_ICW2, WAIT_ICW3, WAIT_ICW4, READY.
- ICW1, accepted in any state (restarts initialization):
  - Latch `ltim`, `single`, and IC4 (`din[0]`, internal).
  - `OCW1` ← 00h; `special_mask` ← 0; `read_mode` ← 0.
  - `EOI_mode`, `sfnm` and `cascade` are cleared.
  - Go to WAIT_ICW2.
- WAIT_ICW2, `A0` = 1: `VEC_ADD` ← `din[7:3]`. Next state:
  - `single` = 0 → WAIT_ICW3.
  - Else IC4 = 1 → WAIT_ICW4.
  - Else → READY.
- WAIT_ICW3, `A0` = 1: `cascade` ← `din`. Next: IC4 ? WAIT_ICW4 : READY.
- WAIT_ICW4, `A0` = 1: `EOI_mode` ← `din[1]`, `sfnm` ← `din[4]`. Go to READY.
- In IDLE and WAIT_*: `A0` = 0 non-ICW1 commits are ignored; state and outputs are unchanged. An `A0` = 1 commit in IDLE is ignored.
- READY:
  - `A0` = 1: `OCW1` ← `din`.
  - OCW2: `EOI_command` ← `din[7:5]`, `int_level` ← `din[2:0]`, pulse `eoi_valid`.
  - OCW3:
    - If `din[1]` (RR) = 1: `read_mode` ← `din[0]`.
    - If `din[6]` (ESMM) = 1: `special_mask` ← `din[5]`.
    - If `din[2]` = 1: pulse `poll_req`.
- `init_done` = 1 exactly when the state is READY.

## Timing
- Reset values:
  - State IDLE; `OCW1` = FFh (all masked until initialized).
  - `VEC_ADD` = 0, `cascade` = 0.
  - `read_mode`, `EOI_command`, `int_level` = 0.
  - All flags and pulses = 0; `init_done` = 0.
  - Sampled `WR_n` history = 1, `CS_n` history = 1.
- Latency:
  - A commit is detected on the first `clk` edge that samples `WR_n` high.
  - Register and state updates are visible immediately after that same edge.
  - `eoi_valid` and `poll_req` are high for exactly that one following cycle.
- Minimum write: `WR_n` low for ≥ 1 sampled cycle, then high for ≥ 1. Back-to-back writes at this rate each commit.
- Any state may be re-entered by ICW1; `init_done` drops on the commit edge.
- Reset during a write (`WR_n` low) clears the history. The subsequent `WR_n` rising edge does not commit; `rst` dominates everything.
- Changes on `din`/`A0` while `WR_n` is low: the last low-cycle value wins.

## Test plan
- Reset then ICW1 = 13h, ICW2 = 48h (single, IC4) → state passes WAIT_ICW4. ICW4 = 03h → `VEC_ADD` = 09h, `EOI_mode` = 1, `OCW1` = 00h, `init_done` = 1.
- ICW1 = 10h, ICW2 = 20h, ICW3 = 04h (cascade, no IC4) → `cascade` = 04h, READY after ICW3, `EOI_mode` = 0.
- In READY: `A0` = 1, `din` = A5h → `OCW1` = A5h. OCW2 = 63h → `EOI_command` = 3, `int_level` = 3, `eoi_valid` high exactly 1 cycle.
- OCW3 = 0Bh → `read_mode` = 1. OCW3 = 68h → `special_mask` = 1. OCW3 = 0Ch → `poll_req` 1-cycle pulse, `read_mode` stays 1.
- In READY, ICW1 = 13h → `init_done` = 0 on commit edge, `OCW1` = 00h. A following OCW2 (`A0` = 0) is ignored, with no `eoi_valid`.
- Assert `rst` while `WR_n` low with `CS_n` = 0, release, then raise `WR_n` → no commit; all reset values hold, `OCW1` = FFh. A write with `CS_n` = 1 is also ignored.

Source files
------------

// File: rtl/pic_init_sequencer.sv
// pic_init_sequencer: decodes CPU command-word writes into the 8259-style
// ICW1..ICW4 initialization sequence and the OCW1..OCW3 operation commands,
// presenting registered configuration and one-cycle command pulses.
module pic_init_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       CS_n,
  input  logic       WR_n,
  input  logic       A0,
  input  logic [7:0] din,
  output logic [7:0] OCW1,
  output logic [4:0] VEC_ADD,
  output logic       read_mode,
  output logic [2:0] EOI_command,
  output logic [2:0] int_level,
  output logic       eoi_valid,
  output logic       poll_req,
  output logic       EOI_mode,
  output logic       ltim,
  output logic       single,
  output logic       special_mask,
  output logic       sfnm,
  output logic [7:0] cascade,
  output logic       init_done
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_ICW2,
    WAIT_ICW3,
    WAIT_ICW4,
    READY
  } state_t;

  typedef struct packed {
    logic [7:0] imr;
    logic [4:0] vec;
    logic       read_mode;
    logic [2:0] eoi_cmd;
    logic [2:0] level;
    logic       eoi_valid;
    logic       poll_req;
    logic       aeoi;
    logic       ltim;
    logic       single;
    logic       ic4;
    logic       smm;
    logic       sfnm;
    logic [7:0] cascade;
  } regs_t;

  localparam regs_t REGS_RESET = '{
    imr: 8'hFF, vec: '0, read_mode: 1'b0, eoi_cmd: '0, level: '0,
    eoi_valid: 1'b0, poll_req: 1'b0, aeoi: 1'b0, ltim: 1'b0,
    single: 1'b0, ic4: 1'b0, smm: 1'b0, sfnm: 1'b0, cascade: '0
  };

  state_t     state, state_next;
  regs_t      regs, regs_next;

  // Write history: the previous clock's view of the bus.
  logic       wr_q, cs_q, a0_q;
  logic [7:0] din_q;
  // Cleared by reset; set once WR_n has been seen high, so a write that was
  // already in progress when reset hit can never commit.
  logic       armed;
  logic       commit;

  assign commit = WR_n && !wr_q && !cs_q;

  // Bus sampling and state/register update; reset dominates everything.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      wr_q  <= 1'b1;
      cs_q  <= 1'b1;
      a0_q  <= 1'b0;
      din_q <= '0;
      armed <= 1'b0;
      state <= IDLE;
      regs  <= REGS_RESET;
    end else begin
      wr_q  <= WR_n || !armed;
      cs_q  <= CS_n;
      a0_q  <= A0;
      din_q <= din;
      armed <= armed || WR_n;
      state <= state_next;
      regs  <= regs_next;
    end
  end

  // Command decode: next state and next register image for each commit.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next          = state;
    regs_next           = regs;
    regs_next.eoi_valid = 1'b0;
    regs_next.poll_req  = 1'b0;

    if (commit) begin
      if (!a0_q && din_q[4]) begin
        // ICW1 restarts initialization from any state.
        regs_next.ltim      = din_q[3];
        regs_next.single    = din_q[1];
        regs_next.ic4       = din_q[0];
        regs_next.imr       = 8'h00;
        regs_next.smm       = 1'b0;
        regs_next.read_mode = 1'b0;
        regs_next.aeoi      = 1'b0;
        regs_next.sfnm      = 1'b0;
        regs_next.cascade   = 8'h00;
        state_next          = WAIT_ICW2;
      end else begin
        unique case (state)
          WAIT_ICW2: if (a0_q) begin
            regs_next.vec = din_q[7:3];
            if (!regs.single)  state_next = WAIT_ICW3;
            else if (regs.ic4) state_next = WAIT_ICW4;
            else               state_next = READY;
          end
          WAIT_ICW3: if (a0_q) begin
            regs_next.cascade = din_q;
            state_next        = regs.ic4 ? WAIT_ICW4 : READY;
          end
          WAIT_ICW4: if (a0_q) begin
            regs_next.aeoi = din_q[1];
            regs_next.sfnm = din_q[4];
            state_next     = READY;
          end
          READY: begin
            if (a0_q) begin
              regs_next.imr = din_q;
            end else if (!din_q[3]) begin
              regs_next.eoi_cmd   = din_q[7:5];
              regs_next.level     = din_q[2:0];
              regs_next.eoi_valid = 1'b1;
            end else begin
              if (din_q[1]) regs_next.read_mode = din_q[0];
              if (din_q[6]) regs_next.smm       = din_q[5];
              if (din_q[2]) regs_next.poll_req  = 1'b1;
            end
          end
          default: ; // IDLE ignores everything but ICW1
        endcase
      end
    end
  end

  assign OCW1         = regs.imr;
  assign VEC_ADD      = regs.vec;
  assign read_mode    = regs.read_mode;
  assign EOI_command  = regs.eoi_cmd;
  assign int_level    = regs.level;
  assign eoi_valid    = regs.eoi_valid;
  assign poll_req     = regs.poll_req;
  assign EOI_mode     = regs.aeoi;
  assign ltim         = regs.ltim;
  assign single       = regs.single;
  assign special_mask = regs.smm;
  assign sfnm         = regs.sfnm;
  assign cascade      = regs.cascade;
  assign init_done    = (state == READY);

endmodule
